// File: rtl/uart_pkg.sv
// Shared definitions for the strobed UART transmitter: parity selection
// constants, FSM state encoding and a frame-length helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_PAR   = 3'd4,
        ST_STOP  = 3'd5
    } uart_state_e;

    // Number of bit periods in one frame: start + data + optional parity + stop.
    function automatic int frame_len(input int data_width, input int parity, input int stop_bits);
        return 1 + data_width + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_strobed_if.sv
// Valid/ready word handshake into the strobed UART transmitter.
interface uart_tx_strobed_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_strobed.sv
// Serial transmitter timed by an external one-cycle bit-rate strobe.
// Shifts words out LSB-first with start, optional parity and stop bits;
// a word accepted during the final stop bit follows with no idle gap.
module uart_tx_strobed
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    uart_tx_strobed_if.slave s_if,
    output logic            tx,
    output logic            busy
);

    localparam int                 IDX_W     = 4;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
    localparam logic               LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e            state_q, state_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   par_q, par_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic                   pend_q, pend_d;
    logic                   accept_s;

    // Parity bit that makes the total number of ones odd or even as configured.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d);
        if (PARITY == PARITY_ODD) begin
            return ~(^d);
        end else begin
            return ^d;
        end
    endfunction

    assign accept_s = s_if.tx_valid && ready_q;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        pend_d     = pend_q;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (accept_s) begin
                    shift_d = s_if.tx_data;
                    par_d   = calc_parity(s_if.tx_data);
                    state_d = ST_SYNC;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            // The accept edge leaves IDLE, so a tick in that cycle is never seen here.
            ST_SYNC: begin
                if (tick) begin
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end else begin
                    state_d = ST_SYNC;
                end
            end

            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = {IDX_W{1'b0}};
                end else begin
                    state_d = ST_START;
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_IDX) begin
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d    = ST_STOP;
                            tx_d       = 1'b1;
                            stop_idx_d = 1'b0;
                            ready_d    = (LAST_STOP == 1'b0);
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_PAR: begin
                if (tick) begin
                    state_d    = ST_STOP;
                    tx_d       = 1'b1;
                    stop_idx_d = 1'b0;
                    ready_d    = (LAST_STOP == 1'b0);
                end else begin
                    state_d = ST_PAR;
                end
            end

            // The shift register is free during STOP, so it holds the pending word.
            ST_STOP: begin
                if (tick && (stop_idx_q == LAST_STOP)) begin
                    if (pend_q || accept_s) begin
                        state_d = ST_START;
                        tx_d    = 1'b0;
                        ready_d = 1'b0;
                        pend_d  = 1'b0;
                        if (accept_s) begin
                            shift_d = s_if.tx_data;
                            par_d   = calc_parity(s_if.tx_data);
                        end else begin
                            shift_d = shift_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else if (tick) begin
                    stop_idx_d = stop_idx_q + 1'b1;
                    ready_d    = ((stop_idx_q + 1'b1) == LAST_STOP);
                end else if (accept_s) begin
                    shift_d = s_if.tx_data;
                    par_d   = calc_parity(s_if.tx_data);
                    pend_d  = 1'b1;
                    ready_d = 1'b0;
                end else begin
                    state_d = ST_STOP;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces an idle line immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            shift_q    <= {DATA_WIDTH{1'b0}};
            par_q      <= 1'b0;
            bit_idx_q  <= {IDX_W{1'b0}};
            stop_idx_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            pend_q     <= pend_d;
        end
    end

    assign tx            = tx_q;
    assign busy          = busy_q;
    assign s_if.tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_strobed.sv
// Self-checking bench for uart_tx_strobed: four configurations (8N1, 8E1,
// 8O1, 7N2) share clock, reset and tick; each frame is checked bit period
// by bit period against a frame built from the bit-level framing rules.
module tb_uart_tx_strobed;
    import uart_pkg::*;

    typedef bit bitq_t[$];

    logic clk;
    logic rst;
    logic tick;
    int   tick_period;
    int   tick_cnt;
    int   n_cmp;
    int   n_fail;

    int cfg_dw  [4] = '{8, 8, 8, 7};
    int cfg_par [4] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_NONE};
    int cfg_sb  [4] = '{1, 1, 1, 2};

    uart_tx_strobed_if #(.DATA_WIDTH(8)) if0 ();
    uart_tx_strobed_if #(.DATA_WIDTH(8)) if1 ();
    uart_tx_strobed_if #(.DATA_WIDTH(8)) if2 ();
    uart_tx_strobed_if #(.DATA_WIDTH(7)) if3 ();

    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] ready_w;

    uart_tx_strobed #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .tick(tick), .s_if(if0.slave), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx_strobed #(.DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .tick(tick), .s_if(if1.slave), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx_strobed #(.DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .tick(tick), .s_if(if2.slave), .tx(tx_w[2]), .busy(busy_w[2]));
    uart_tx_strobed #(.DATA_WIDTH(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .tick(tick), .s_if(if3.slave), .tx(tx_w[3]), .busy(busy_w[3]));

    assign ready_w = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Periodic bit strobe, one clk wide, updated just after each rising edge.
    initial begin
        tick     = 1'b0;
        tick_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_cnt + 1 >= tick_period) tick_cnt = 0;
            else tick_cnt = tick_cnt + 1;
            tick = (tick_cnt == 0);
        end
    end

    // Reference frame: start 0, data LSB first, optional parity, stop 1s.
    function automatic bitq_t build_frame(input int sel, input logic [8:0] d);
        bitq_t q;
        int    ones;
        q = {};
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < cfg_dw[sel]; i++) begin
            q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (cfg_par[sel] == PARITY_EVEN) q.push_back((ones % 2) == 1);
        else if (cfg_par[sel] == PARITY_ODD) q.push_back((ones % 2) == 0);
        for (int i = 0; i < cfg_sb[sel]; i++) q.push_back(1'b1);
        return q;
    endfunction

    task automatic drive(input int sel, input bit v, input logic [8:0] d);
        case (sel)
            0: begin if0.tx_valid = v; if0.tx_data = d[7:0]; end
            1: begin if1.tx_valid = v; if1.tx_data = d[7:0]; end
            2: begin if2.tx_valid = v; if2.tx_data = d[7:0]; end
            3: begin if3.tx_valid = v; if3.tx_data = d[6:0]; end
            default: ;
        endcase
    endtask

    // Present a word and return #1 after the accepting edge.
    task automatic send(input int sel, input logic [8:0] d, input bit drop);
        bit ok;
        ok = 1'b0;
        drive(sel, 1'b1, d);
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge clk);
            if (ready_w[sel]) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (drop) drive(sel, 1'b0, d);
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout sel=%0d: tx_ready never high, required high within 2000 clk", sel);
        end
    endtask

    // Follow the line from just after an accept through the tick ending the
    // last expected bit; every sample in a bit period must hold that bit.
    task automatic check_frame(input int sel, input string name, input bitq_t exp_q,
                               input bit chk_ready, output int pre_cyc);
        int   j;
        int   cyc;
        bit   bad;
        bit   t;
        bit   exp_rdy;
        logic bad_tx;
        logic bad_rdy;
        j = -1; cyc = 0; bad = 1'b0; pre_cyc = -1; bad_tx = 1'b0; bad_rdy = 1'b0;
        while (j < exp_q.size() && cyc < 3000) begin
            @(posedge clk);
            t = tick;
            @(negedge clk);
            cyc++;
            if (t) begin
                n_cmp++;
                if (bad) begin
                    n_fail++;
                    if (j < 0)
                        $display("FAIL %s pre_start: tx=%b tx_ready=%b, required tx=1 tx_ready=0 busy=1",
                                 name, bad_tx, bad_rdy);
                    else
                        $display("FAIL %s bit%0d: tx=%b tx_ready=%b, required tx=%b tx_ready=%b",
                                 name, j, bad_tx, bad_rdy, exp_q[j], (j == exp_q.size() - 1));
                end
                if (j < 0) pre_cyc = cyc;
                j++;
                bad = 1'b0;
            end
            if (j >= exp_q.size()) break;
            if (j < 0) begin
                if (tx_w[sel] !== 1'b1 || busy_w[sel] !== 1'b1 || ready_w[sel] !== 1'b0) begin
                    bad = 1'b1; bad_tx = tx_w[sel]; bad_rdy = ready_w[sel];
                end
            end else begin
                exp_rdy = (j == exp_q.size() - 1);
                if (tx_w[sel] !== exp_q[j] || busy_w[sel] !== 1'b1 ||
                    (chk_ready && ready_w[sel] !== exp_rdy)) begin
                    bad = 1'b1; bad_tx = tx_w[sel]; bad_rdy = ready_w[sel];
                end
            end
        end
        n_cmp++;
        if (j < exp_q.size()) begin
            n_fail++;
            $display("FAIL %s timeout: reached bit %0d, required %0d bits", name, j, exp_q.size());
        end else if (tx_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0 || ready_w[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s end: tx=%b busy=%b tx_ready=%b, required tx=1 busy=0 tx_ready=1",
                     name, tx_w[sel], busy_w[sel], ready_w[sel]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            n_cmp++;
            if (tx_w[s] !== 1'b1 || ready_w[s] !== 1'b1 || busy_w[s] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state sel=%0d: tx=%b tx_ready=%b busy=%b, required 1 1 0",
                         s, tx_w[s], ready_w[s], busy_w[s]);
            end
        end
    endtask

    task automatic test_8n1();
        int pre;
        tick_period = 4;
        repeat (8) @(posedge clk);
        send(0, 9'h055, 1'b1);
        check_frame(0, "8n1_55", build_frame(0, 9'h055), 1'b1, pre);
    endtask

    task automatic test_parity();
        int pre;
        tick_period = 4;
        send(1, 9'h055, 1'b1);
        check_frame(1, "8e1_55", build_frame(1, 9'h055), 1'b1, pre);
        send(2, 9'h055, 1'b1);
        check_frame(2, "8o1_55", build_frame(2, 9'h055), 1'b1, pre);
        send(1, 9'h007, 1'b1);
        check_frame(1, "8e1_07", build_frame(1, 9'h007), 1'b1, pre);
    endtask

    task automatic test_back_to_back();
        int    pre;
        bitq_t q;
        tick_period = 3;
        repeat (6) @(posedge clk);
        q = build_frame(0, 9'h0A3);
        q = {q, build_frame(0, 9'h03C)};
        send(0, 9'h0A3, 1'b0);
        fork
            send(0, 9'h03C, 1'b1);
            check_frame(0, "b2b_a3_3c", q, 1'b0, pre);
        join
    endtask

    task automatic test_accept_on_tick();
        int pre;
        tick_period = 5;
        repeat (7) @(posedge clk);
        do begin
            @(posedge clk);
            #2;
        end while (tick !== 1'b1);
        send(0, 9'h0C6, 1'b1);
        check_frame(0, "accept_on_tick", build_frame(0, 9'h0C6), 1'b1, pre);
        n_cmp++;
        if (pre !== 5) begin
            n_fail++;
            $display("FAIL accept_on_tick_latency: start after %0d clk, required 5", pre);
        end
    endtask

    task automatic test_two_stop();
        int pre;
        tick_period = 4;
        send(3, 9'h07F, 1'b1);
        check_frame(3, "7n2_7f", build_frame(3, 9'h07F), 1'b1, pre);
    endtask

    task automatic test_reset_mid_frame();
        int ticks;
        int pre;
        tick_period = 4;
        send(0, 9'h000, 1'b1);
        ticks = 0;
        for (int n = 0; n < 200 && ticks < 5; n++) begin
            @(posedge clk);
            if (tick) ticks++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: tx=%b busy=%b, required tx=1 busy=0", tx_w[0], busy_w[0]);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (tx_w[0] !== 1'b1 || ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release: tx=%b tx_ready=%b busy=%b, required 1 1 0",
                     tx_w[0], ready_w[0], busy_w[0]);
        end
        send(0, 9'h05A, 1'b1);
        check_frame(0, "after_reset_5a", build_frame(0, 9'h05A), 1'b1, pre);
    endtask

    task automatic test_random();
        int          sel;
        int          pre;
        logic [8:0]  d;
        for (int k = 0; k < 8; k++) begin
            sel = $urandom_range(3, 0);
            tick_period = $urandom_range(6, 1);
            repeat ($urandom_range(5, 1)) @(posedge clk);
            #1;
            d = 9'($urandom_range(511, 0));
            if (cfg_dw[sel] == 7) d = d & 9'h07F;
            else d = d & 9'h0FF;
            send(sel, d, 1'b1);
            check_frame(sel, $sformatf("rand%0d_sel%0d_%h", k, sel, d), build_frame(sel, d), 1'b1, pre);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        tick_period = 4;
        rst = 1'b1;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 9'h000);
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_accept_on_tick();
        test_two_stop();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
